// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares the single request port of the SDRAM/BRAM controller
//               between the CPU Wishbone data path (M0) and the accelerator
//               DMA engine (M1). Single-beat transactions, round-robin with
//               bounded stickiness (MAX_BURST consecutive grants while the
//               other requester waits).
//               Optional performance counters are enabled by defining the
//               macro ARB_PERF_CNT_EN; without it the perf_* ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // M0: CPU data path
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  // M1: accelerator DMA
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  // Downstream controller port
  output logic              s_req,
  output logic              s_we,
  output logic [3:0]        s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  // Performance counters
  output logic [31:0]       perf_m0_cnt,
  output logic [31:0]       perf_m1_cnt,
  output logic [31:0]       perf_wait_cnt
);

  // Run counter must be able to hold the value MAX_BURST itself.
  localparam int c_cnt_w = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0] c_run_one   = c_cnt_w'(1);

  // Owner encoding: one bit, 0 = M0, 1 = M1.
  localparam logic c_m0 = 1'b0;
  localparam logic c_m1 = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic [c_cnt_w-1:0]  r_run_cnt;
  // Remembers whether the in-flight grant went to the previous owner, so
  // the run counter can be updated when the ack arrives.
  logic                r_same;

  logic                w_any_req;
  logic                w_sticky;
  logic                w_win;
  logic                w_busy;
  logic [c_cnt_w-1:0]  w_run_inc;

  assign w_any_req = m0_req | m1_req;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_run_inc = (r_run_cnt >= c_max_burst) ? c_max_burst
                                                : (r_run_cnt + c_run_one);

  // Winner selection: a lone requester wins; under contention the owner
  // keeps the port while its run is non-zero and below MAX_BURST.
  always_comb begin
    w_sticky = (r_run_cnt != '0) && (r_run_cnt < c_max_burst);
    if (m0_req && m1_req) begin
      w_win = w_sticky ? r_owner : ~r_owner;
    end else begin
      w_win = m1_req;
    end
  end

  // Arbitration FSM with registered downstream request fields.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= c_m1;
      r_run_cnt <= '0;
      r_same    <= 1'b0;
      s_req     <= 1'b0;
      s_we      <= 1'b0;
      s_sel     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            s_req   <= 1'b1;
            s_we    <= w_win ? m1_we    : m0_we;
            s_sel   <= w_win ? m1_sel   : m0_sel;
            s_addr  <= w_win ? m1_addr  : m0_addr;
            s_wdata <= w_win ? m1_wdata : m0_wdata;
            r_same  <= (w_win == r_owner);
            r_owner <= w_win;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Fields stay frozen until the controller completes the beat.
          if (s_ack) begin
            s_req     <= 1'b0;
            r_run_cnt <= r_same ? w_run_inc : c_run_one;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion is routed to the current owner in the same cycle as s_ack.
  assign m0_ack   = s_ack & w_busy & (r_owner == c_m0);
  assign m1_ack   = s_ack & w_busy & (r_owner == c_m1);
  assign m0_rdata = (r_owner == c_m0) ? s_rdata : '0;
  assign m1_rdata = (r_owner == c_m1) ? s_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_m0_cnt;
  logic [31:0] r_perf_m1_cnt;
  logic [31:0] r_perf_wait_cnt;
  logic        w_wait;

  // A cycle counts as waiting when any requester is not the active grant.
  assign w_wait = (m0_req & ~(w_busy & (r_owner == c_m0))) |
                  (m1_req & ~(w_busy & (r_owner == c_m1)));

  // Free-running, wrapping transaction and wait counters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_perf_m0_cnt   <= '0;
      r_perf_m1_cnt   <= '0;
      r_perf_wait_cnt <= '0;
    end else begin
      if (m0_ack) r_perf_m0_cnt   <= r_perf_m0_cnt + 32'd1;
      if (m1_ack) r_perf_m1_cnt   <= r_perf_m1_cnt + 32'd1;
      if (w_wait) r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
    end
  end

  assign perf_m0_cnt   = r_perf_m0_cnt;
  assign perf_m1_cnt   = r_perf_m1_cnt;
  assign perf_wait_cnt = r_perf_wait_cnt;
`else
  assign perf_m0_cnt   = 32'd0;
  assign perf_m1_cnt   = 32'd0;
  assign perf_wait_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Directed self-checking bench for sdram_port_arbiter.
//               Perf-counter checks follow the ARB_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam logic [31:0] A0 = 32'h3800_0010;
  localparam logic [31:0] A1 = 32'h3800_0200;
  localparam logic [31:0] W0 = 32'h0000_AAAA;
  localparam logic [31:0] W1 = 32'h5555_0000;

  logic        wb_clk_i, wb_rst_i;
  logic        m0_req, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [31:0] perf_m0_cnt, perf_m1_cnt, perf_wait_cnt;

  int checks;
  int errors;

  // Bench view of which requester is being served (set from expectations).
  logic        tb_busy;
  logic        tb_own;
  int unsigned tb_wait;

  sdram_port_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata),
    .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
    .perf_wait_cnt(perf_wait_cnt)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Reference wait-cycle count, built from the bench's own grant schedule.
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) tb_wait <= 0;
    else if ((m0_req && !(tb_busy && !tb_own)) || (m1_req && !(tb_busy && tb_own)))
      tb_wait <= tb_wait + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  // Wait (bounded) for a grant, check it targets exp_m1, then ack it.
  task automatic serve(input logic exp_m1, input int bound, input logic [31:0] rd);
    int n;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (s_req !== 1'b1 && n < bound);
    chk("grant_s_req", {31'd0, s_req}, 32'd1);
    chk("grant_addr", s_addr, exp_m1 ? A1 : A0);
    chk("grant_we", {31'd0, s_we}, exp_m1 ? 32'd1 : 32'd0);
    chk("grant_wdata", s_wdata, exp_m1 ? W1 : W0);
    tb_busy = 1'b1;
    tb_own  = exp_m1;
    s_ack   = 1'b1;
    s_rdata = rd;
    #1;
    chk("ack_m0", {31'd0, m0_ack}, {31'd0, !exp_m1});
    chk("ack_m1", {31'd0, m1_ack}, {31'd0, exp_m1});
    chk("ack_rdata", exp_m1 ? m1_rdata : m0_rdata, rd);
    @(negedge wb_clk_i);
    s_ack   = 1'b0;
    s_rdata = 32'd0;
    tb_busy = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    tb_busy = 1'b0; tb_own = 1'b0;
    wb_rst_i = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_sel = 4'hF; m0_addr = A0; m0_wdata = W0;
    m1_req = 1'b0; m1_we = 1'b1; m1_sel = 4'h3; m1_addr = A1; m1_wdata = W1;
    s_ack = 1'b0; s_rdata = 32'h1234_5678;

    // Reset state: owner is M1, so only m1_rdata follows s_rdata.
    do_reset();
    @(negedge wb_clk_i);
    chk("rst_s_req", {31'd0, s_req}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_sel", {28'd0, s_sel}, 32'd0);
    chk("rst_perf_m0", perf_m0_cnt, 32'd0);
    chk("rst_perf_wait", perf_wait_cnt, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'h1234_5678);
    s_rdata = 32'd0;

    // M0 read alone, ack three cycles after s_req.
    m0_req = 1'b1;
    @(negedge wb_clk_i);
    chk("rd_s_req", {31'd0, s_req}, 32'd1);
    chk("rd_s_addr", s_addr, A0);
    chk("rd_s_we", {31'd0, s_we}, 32'd0);
    chk("rd_s_sel", {28'd0, s_sel}, 32'hF);
    repeat (2) begin
      @(negedge wb_clk_i);
      chk("rd_wait_m0_ack", {31'd0, m0_ack}, 32'd0);
      chk("rd_wait_m1_ack", {31'd0, m1_ack}, 32'd0);
      chk("rd_hold_addr", s_addr, A0);
    end
    @(negedge wb_clk_i);
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
    @(negedge wb_clk_i);
    s_ack = 1'b0; s_rdata = 32'd0; m0_req = 1'b0;
    chk("rd_s_req_drop", {31'd0, s_req}, 32'd0);

    // Continuous contention after reset: M0 x4, M1 x4, M0.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 9; i++) serve(((i / 4) % 2) == 1, 2, 32'hA000_0000 + i);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge wb_clk_i);
    chk("rr_idle", {31'd0, s_req}, 32'd0);

    // M1 streams two beats, drops; waiting M0 wins the next IDLE cycle
    // with a fresh run of 1, so it keeps the port for 3 more beats.
    do_reset();
    m1_req = 1'b1;
    serve(1'b1, 2, 32'hB000_0001);
    m0_req = 1'b1;
    serve(1'b1, 1, 32'hB000_0002);
    m1_req = 1'b0;
    serve(1'b0, 1, 32'hB000_0003);
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) serve(1'b0, 1, 32'hB000_0010 + i);
    serve(1'b1, 1, 32'hB000_0020);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge wb_clk_i);

    // Reset while BUSY: s_req drops immediately, no ack, M1 then served.
    m0_req = 1'b1;
    @(negedge wb_clk_i);
    chk("mid_s_req", {31'd0, s_req}, 32'd1);
    #1 wb_rst_i = 1'b1; s_ack = 1'b1;
    #1;
    chk("mid_rst_s_req", {31'd0, s_req}, 32'd0);
    chk("mid_rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("mid_rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    m0_req = 1'b0; s_ack = 1'b0;
    #1 wb_rst_i = 1'b0; m1_req = 1'b1;
    serve(1'b1, 2, 32'hC000_0001);
    m1_req = 1'b0;

    // Stray s_ack while IDLE.
    s_ack = 1'b1;
    #1;
    chk("stray_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("stray_m1_ack", {31'd0, m1_ack}, 32'd0);
    @(negedge wb_clk_i);
    s_ack = 1'b0;
    chk("stray_s_req", {31'd0, s_req}, 32'd0);
    chk("stray_s_addr", s_addr, A1);
    chk("stray_s_wdata", s_wdata, W1);
    @(negedge wb_clk_i);
    chk("stray_s_req2", {31'd0, s_req}, 32'd0);

    // Perf scenario: M0 x4, M1 x3 under contention, then M0 alone.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) serve(1'b0, 2, 32'hD000_0000 + i);
    for (int i = 0; i < 3; i++) serve(1'b1, 2, 32'hD100_0000 + i);
    m1_req = 1'b0;
    serve(1'b0, 2, 32'hD200_0000);
    m0_req = 1'b0;
    @(negedge wb_clk_i);
`ifdef ARB_PERF_CNT_EN
    chk("perf_m0", perf_m0_cnt, 32'd5);
    chk("perf_m1", perf_m1_cnt, 32'd3);
    chk("perf_wait", perf_wait_cnt, tb_wait);
`else
    chk("perf_m0_off", perf_m0_cnt, 32'd0);
    chk("perf_m1_off", perf_m1_cnt, 32'd0);
    chk("perf_wait_off", perf_wait_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
